// File: rtl/cic_comb_decimator_if.sv
// Output stream of the CIC comb/decimator: registered sample, valid/ready handshake
// and the sticky overflow flag.
interface cic_comb_decimator_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             overflow;

  modport master (
    output data,
    output valid,
    output overflow,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  overflow,
    output ready
  );
endinterface

// File: rtl/cic_comb_decimator.sv
// CIC decimation and comb section: keeps one integrator sample in every R and runs
// it through STAGES pipelined differentiators into a single valid/ready output register.
module cic_comb_decimator #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 5,
  parameter int unsigned DELAY  = 1,
  parameter int unsigned DEC_W  = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [DEC_W-1:0]     cfg_decim_i,
  input  logic [WIDTH-1:0]     data_i,
  cic_comb_decimator_if.master out_if
);

  logic             w_flush;
  logic             w_dec;
  logic [DEC_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;
  logic [WIDTH-1:0] w_last_y;
  logic             w_last_v;

  assign w_flush = rst_i | clr_i;
  // >= rather than == so a live cfg change can only shorten one period
  assign w_dec   = en_i && (r_cnt >= cfg_decim_i);

  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= w_dec ? '0 : r_cnt + DEC_W'(1);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_x;
    logic             w_q;
    logic [WIDTH-1:0] r_y;
    logic             r_v;
    logic [WIDTH-1:0] r_del [DELAY];

    if (k == 0) begin : g_first
      assign w_x = data_i;
      assign w_q = w_dec;
    end else begin : g_next
      assign w_x = g_stage[k-1].r_y;
      assign w_q = g_stage[k-1].r_v;
    end

    always_ff @(posedge clk_i) begin
      if (w_flush) begin
        r_v <= 1'b0;
        r_y <= '0;
        for (int d = 0; d < DELAY; d++) begin
          r_del[d] <= '0;
        end
      end else begin
        r_v <= w_q;
        if (w_q) begin
          r_y      <= w_x - r_del[DELAY-1];
          r_del[0] <= w_x;
          for (int d = 1; d < DELAY; d++) begin
            r_del[d] <= r_del[d-1];
          end
        end
      end
    end
  end

  assign w_last_y = g_stage[STAGES-1].r_y;
  assign w_last_v = g_stage[STAGES-1].r_v;

  // The comb chain never stalls: a result arriving while the register is full is dropped
  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_last_v) begin
      if (!r_valid || out_if.ready) begin
        r_data  <= w_last_y;
        r_valid <= 1'b1;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (out_if.ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_if.data     = r_data;
  assign out_if.valid    = r_valid;
  assign out_if.overflow = r_ovf;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator: three instances (1 stage M=1, 5 stages M=1,
// 1 stage M=2) share one stimulus stream; each phase checks the relevant instance.
module tb_cic_comb_decimator;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [9:0]  cfg;
  logic [63:0] din;
  logic        ready;

  int n_checks;
  int n_errors;

  cic_comb_decimator_if #(.WIDTH(64)) if1 ();
  cic_comb_decimator_if #(.WIDTH(64)) if5 ();
  cic_comb_decimator_if #(.WIDTH(64)) if2 ();

  assign if1.ready = ready;
  assign if5.ready = ready;
  assign if2.ready = ready;

  cic_comb_decimator #(.WIDTH(64), .STAGES(1), .DELAY(1), .DEC_W(10)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .cfg_decim_i(cfg), .data_i(din),
    .out_if(if1)
  );

  cic_comb_decimator #(.WIDTH(64), .STAGES(5), .DELAY(1), .DEC_W(10)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .cfg_decim_i(cfg), .data_i(din),
    .out_if(if5)
  );

  cic_comb_decimator #(.WIDTH(64), .STAGES(1), .DELAY(2), .DEC_W(10)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .cfg_decim_i(cfg), .data_i(din),
    .out_if(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [9:0] c);
    cfg = c;
    clr = 1'b1;
    en  = 1'b0;
    cyc();
    clr = 1'b0;
  endtask

  // Ramp 3*n with R=4 from a cleared counter/delay state. Kept samples are 9,21,33,45,...
  // M=1 gives 9 then 12; M=2 gives 9, 21, then 24.
  task automatic ramp_r4(input string tag);
    logic        exp_v;
    logic [63:0] exp1;
    logic [63:0] exp2;
    ready = 1'b1;
    for (int n = 0; n <= 16; n++) begin
      din = 64'(3 * n);
      en  = 1'b1;
      cyc();
      exp_v = (n % 4 == 0) && (n > 0);
      exp1  = (n == 4) ? 64'd9 : 64'd12;
      exp2  = (n == 4) ? 64'd9 : ((n == 8) ? 64'd21 : 64'd24);
      check_eq($sformatf("%s_v1_%0d", tag, n), 64'(if1.valid), 64'(exp_v));
      check_eq($sformatf("%s_v2_%0d", tag, n), 64'(if2.valid), 64'(exp_v));
      if (exp_v) begin
        check_eq($sformatf("%s_d1_%0d", tag, n), if1.data, exp1);
        check_eq($sformatf("%s_d2_%0d", tag, n), if2.data, exp2);
      end
    end
    en = 1'b0;
  endtask

  logic [63:0] step_tab [10];
  logic [63:0] imp_tab  [10];
  logic [63:0] wrap_tab [4];

  initial begin
    // 5 cascaded integrators fed a unit step / unit impulse
    step_tab = '{64'd1, 64'd6, 64'd21, 64'd56, 64'd126, 64'd252, 64'd462, 64'd792,
                 64'd1287, 64'd2002};
    imp_tab  = '{64'd1, 64'd5, 64'd15, 64'd35, 64'd70, 64'd126, 64'd210, 64'd330,
                 64'd495, 64'd715};
    wrap_tab = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd4};
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; cfg = '0; din = '0; ready = 1'b0;
    cyc();
    cyc();
    check_eq("rst_d1", if1.data, 64'd0);
    check_eq("rst_v1", 64'(if1.valid), 64'd0);
    check_eq("rst_o1", 64'(if1.overflow), 64'd0);
    check_eq("rst_d5", if5.data, 64'd0);
    check_eq("rst_v5", 64'(if5.valid), 64'd0);
    check_eq("rst_o5", 64'(if5.overflow), 64'd0);
    rst = 1'b0;

    // Decimation by 4, ramp input
    do_clear(10'd3);
    ramp_r4("ramp");

    // R=1 through 5 combs: step in -> all ones out; impulse in -> 1 then zeros
    for (int t = 0; t < 2; t++) begin
      do_clear(10'd0);
      ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
        din = (t == 0) ? step_tab[n] : imp_tab[n];
        en  = 1'b1;
        cyc();
        check_eq($sformatf("cic%0d_v_%0d", t, n), 64'(if5.valid), 64'(n >= 5));
        if (n >= 5) begin
          check_eq($sformatf("cic%0d_d_%0d", t, n), if5.data,
                   (t == 0 || n == 5) ? 64'd1 : 64'd0);
        end
      end
      en = 1'b0;
    end

    // Modulo wrap-around
    do_clear(10'd0);
    ready = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      if (n < 4) begin
        din = wrap_tab[n];
        en  = 1'b1;
      end else begin
        en = 1'b0;
      end
      cyc();
      if (n >= 1) begin
        check_eq($sformatf("wrap_v_%0d", n), 64'(if1.valid), 64'd1);
        check_eq($sformatf("wrap_d_%0d", n), if1.data,
                 (n == 1) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'd4);
      end
    end

    // Backpressure: second result dropped, overflow sticky until clear
    do_clear(10'd0);
    ready = 1'b0;
    din = 64'd10; en = 1'b1; cyc(); en = 1'b0; cyc();
    check_eq("bp_v0", 64'(if1.valid), 64'd1);
    check_eq("bp_d0", if1.data, 64'd10);
    check_eq("bp_o0", 64'(if1.overflow), 64'd0);
    din = 64'd25; en = 1'b1; cyc(); en = 1'b0; cyc();
    check_eq("bp_v1", 64'(if1.valid), 64'd1);
    check_eq("bp_d1", if1.data, 64'd10);
    check_eq("bp_o1", 64'(if1.overflow), 64'd1);
    ready = 1'b1;
    cyc();
    check_eq("bp_v2", 64'(if1.valid), 64'd0);
    check_eq("bp_d2", if1.data, 64'd10);
    check_eq("bp_o2", 64'(if1.overflow), 64'd1);
    cyc();
    check_eq("bp_o3", 64'(if1.overflow), 64'd1);
    do_clear(10'd0);
    check_eq("bp_clr_o", 64'(if1.overflow), 64'd0);
    check_eq("bp_clr_d", if1.data, 64'd0);

    // Back-to-back results with ready=1: load and accept in the same cycle
    din = 64'd5; en = 1'b1; cyc();
    din = 64'd12; cyc();
    en = 1'b0;
    check_eq("b2b_v0", 64'(if1.valid), 64'd1);
    check_eq("b2b_d0", if1.data, 64'd5);
    cyc();
    check_eq("b2b_v1", 64'(if1.valid), 64'd1);
    check_eq("b2b_d1", if1.data, 64'd7);
    check_eq("b2b_o1", 64'(if1.overflow), 64'd0);
    cyc();
    check_eq("b2b_v2", 64'(if1.valid), 64'd0);

    // Clear two cycles after dec with 5 stages: in-flight sample vanishes
    do_clear(10'd0);
    din = 64'd100; en = 1'b1; cyc(); en = 1'b0; cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    check_eq("mid_v_0", 64'(if5.valid), 64'd0);
    for (int i = 1; i < 8; i++) begin
      cyc();
      check_eq($sformatf("mid_v_%0d", i), 64'(if5.valid), 64'd0);
    end
    din = 64'd100; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      en = 1'b0;
      check_eq($sformatf("fresh_v_%0d", i), 64'(if5.valid), 64'(i == 6));
    end
    check_eq("fresh_d", if5.data, 64'd100);

    // Clear with en=1 partway through a decimation period must not count that strobe
    do_clear(10'd3);
    din = 64'd3; en = 1'b1; cyc(); cyc();
    clr = 1'b1; cyc(); clr = 1'b0; en = 1'b0;
    check_eq("clren_v", 64'(if1.valid), 64'd0);
    ramp_r4("clren");

    // Reset wins over a pending en/ready and leaves the counter at zero
    do_clear(10'd0);
    ready = 1'b0;
    din = 64'd10; en = 1'b1; cyc();
    din = 64'd30; cyc();
    en = 1'b0; cyc(); cyc();
    check_eq("pre_rst_o", 64'(if1.overflow), 64'd1);
    cfg = 10'd3; rst = 1'b1; en = 1'b1; ready = 1'b1; din = 64'd77;
    cyc();
    rst = 1'b0; en = 1'b0;
    check_eq("rstp_d", if1.data, 64'd0);
    check_eq("rstp_v", 64'(if1.valid), 64'd0);
    check_eq("rstp_o", 64'(if1.overflow), 64'd0);
    ramp_r4("rstp");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cic_comb_decimator.md
# cic_comb_decimator

Decimation and comb section of the CIC decimation filter in the uDMA I2S/PDM path. It sits directly downstream of the cascaded CIC integrator chain. It counts integrator sample strobes and keeps one sample in every R. Each kept sample passes through a pipelined chain of STAGES comb (differentiator) stages, and the result is presented on a valid/ready output held in a single output register.

## Interface
- WIDTH, 64: data width; matches the integrator accumulator width.
- STAGES, 5: number of comb stages. Range 1..8.
- DELAY, 1: differential delay M per comb stage. Allowed values: 1 or 2.
- DEC_W, 10: width of the decimation ratio field.
- clk_i  in  1  single clock. All logic is rising-edge.
- rst_i  in  1  reset. Synchronous, active-high.
- en_i  in  1  integrator sample strobe. data_i is valid in cycles where en_i=1.
- clr_i  in  1  synchronous clear of all state. Issued together with the integrator clear.
- cfg_decim_i  in  DEC_W  decimation ratio minus one (R-1). A value of 0 means R=1.
- data_i  in  WIDTH  output of the last integrator stage.
- data_o  out  WIDTH  filtered, decimated sample.
- valid_o  out  1  data_o holds an unconsumed sample.
- ready_i  in  1  consumer accepts data_o when valid_o=1 and ready_i=1.
- overflow_o  out  1  sticky: a result was dropped because of backpressure.

## Operation
- Priority in every register: rst_i, then clr_i, then normal operation. rst_i and clr_i have identical effect: the decimation counter, all delay lines, all stage registers, stage valid bits, data_o, valid_o and overflow_o all go to 0.
- Decimation counter `cnt` (DEC_W bits):
  - It advances only in cycles with en_i=1.
  - If en_i=1 and cnt >= cfg_decim_i, a decimation strobe `dec` fires in that cycle and cnt goes to 0.
  - If en_i=1 and cnt < cfg_decim_i, cnt increments.
  - The first sample kept after clear is the (R)th en_i pulse.
  - cfg_decim_i is compared live. Software changes it only while clr_i is asserted; the >= compare bounds the glitch when this rule is broken.
- Comb stage k (k = 0..STAGES-1):
  - Input of stage 0 is data_i, qualified by dec. Input of stage k>0 is the output of stage k-1, qualified by v[k-1].
  - When the input is qualified, the stage registers y = x - x_del, where x_del is the stage input from DELAY qualified events earlier. The delay line then shifts x in, and v[k] is set for one cycle.
  - In all other cycles the delay line and y hold, and v[k] = 0.
  - Delay-line contents start at 0 after reset/clear. The first outputs therefore contain the start-up transient; they are not suppressed.
- Arithmetic: two's-complement, modulo 2^WIDTH, with no saturation. Wrap-around in the integrators cancels exactly in the combs, provided WIDTH >= input bits + STAGES*log2(R*M).
- Output register:
  - When v[STAGES-1]=1 and either valid_o=0 or ready_i=1: data_o takes the stage result and valid_o is set to 1.
  - When v[STAGES-1]=1, valid_o=1 and ready_i=0: the new result is dropped, data_o and valid_o hold, and overflow_o is set to 1.
  - When valid_o=1, ready_i=1 and there is no new result: valid_o goes to 0 and data_o holds its value.
  - overflow_o stays at 1 until rst_i or clr_i.
- Backpressure never stalls the comb pipeline or the counter. Input samples are never refused.

## Timing
- Reset values of all outputs: data_o=0, valid_o=0, overflow_o=0.
- dec in cycle t leads to v[0] in cycle t+1, v[k] in cycle t+1+k, and valid_o high from cycle t+STAGES+1. Latency is STAGES+1 cycles.
- Throughput: one result per cycle when R=1 and en_i is held at 1.
- Simultaneous load and accept in the same cycle: valid_o stays at 1, data_o updates, and overflow_o is not set.
- If clr_i is asserted while samples are in flight, they are discarded. No valid_o pulse may appear in the cycle after the clear.
- A clr_i cycle in which en_i=1 does not count that strobe.
- data_o is registered. There is no combinational path from inputs to outputs other than through registers.

## Test plan
- Ramp input, R=4 (cfg=3), STAGES=1, M=1. Drive data_i = 3*n on every en_i pulse with ready_i=1. Required: valid_o pulses on every 4th strobe, 2 cycles after the strobe. data_o is 9 first, then 12 steady.
- R=1, STAGES=5, M=1. Apply a unit step into 5 cascaded integrators; the input is cumulative, with en_i=1 every cycle. Required: after a 6-cycle latency, data_o shows the impulse sequence of the cascade, and the steady-state output is 1.
- Wrap-around, WIDTH=64, STAGES=1, R=1. Drive data_i = 2^64-8, 2^64-4, 0, 4. Required: data_o is 4 for each sample after the first.
- Backpressure. Hold ready_i=0 while two results are produced. Required: data_o keeps the first result, overflow_o becomes 1 when the second arrives, and it stays at 1 after ready_i=1 until clr_i.
- Clear mid-flight with STAGES=5. Assert clr_i two cycles after dec. Required: no valid_o pulse follows, and counter and delays are zero. The next output after clear equals the output of a fresh-start run with the same stimulus.
- Reset and clear priority. Assert rst_i together with en_i=1 and ready_i=1. Required: all outputs are 0 in the next cycle, and the counter is not incremented.
